// File: rtl/rib_arbiter_pkg.sv
// Shared RIB field widths, the forwarded-request record and the index-width helper.
package rib_arbiter_pkg;

  localparam int RIB_ADDR_W = 32;
  localparam int RIB_MASK_W = 4;
  localparam int RIB_DATA_W = 32;

  typedef struct packed {
    logic [RIB_ADDR_W-1:0] addr;
    logic                  wrcs;
    logic [RIB_MASK_W-1:0] mask;
    logic [RIB_DATA_W-1:0] wdata;
  } rib_req_t;

  // Bits needed to index n items; never less than one so ports stay legal.
  function automatic int rib_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rib_arb_fifo.sv
// In-order index queue: remembers which master owns each outstanding transaction.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module rib_arb_fifo
  import rib_arbiter_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = rib_idx_w(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Advance a pointer; the slot index wraps at DEPTH and toggles the wrap bit.
  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) begin
      return {~p[AW], {AW{1'b0}}};
    end
    return p + (AW + 1)'(1);
  endfunction

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer state; reset flushes every outstanding entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rib_arbiter.sv
// Round-robin arbiter sharing one RIB slave port among M masters. Requests are
// forwarded combinationally; granted master indices queue up so responses
// return to their owners in order.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int M     = 2,
  parameter int OUTST = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [M-1:0]          i_m_req,
  input  logic [32*M-1:0]       i_m_addr,
  input  logic [M-1:0]          i_m_wrcs,
  input  logic [4*M-1:0]        i_m_mask,
  input  logic [32*M-1:0]       i_m_wdata,
  output logic [M-1:0]          o_m_gnt,
  output logic [M-1:0]          o_m_rsp,
  output logic [31:0]           o_m_rdata,
  input  logic [M-1:0]          i_m_rdy,
  output logic                  o_s_req,
  output logic [31:0]           o_s_addr,
  output logic                  o_s_wrcs,
  output logic [3:0]            o_s_mask,
  output logic [31:0]           o_s_wdata,
  input  logic                  i_s_gnt,
  input  logic                  i_s_rsp,
  input  logic [31:0]           i_s_rdata,
  output logic                  o_s_rdy,
  output logic                  o_err
);

  localparam int IW = rib_idx_w(M);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] lock_idx;
  logic          lock;
  logic [IW-1:0] sel;
  logic [IW-1:0] mux_idx;
  logic [IW-1:0] head;
  logic          found;
  int            cand;
  logic          full;
  logic          empty;
  logic          hs;
  logic          pop;
  rib_req_t      fwd;

  // Pick the locked master, else the first requester at or after rr_ptr.
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    cand  = 0;
    if (lock) begin
      sel = lock_idx;
    end else begin
      for (int i = 0; i < M; i++) begin
        cand = (int'(rr_ptr) + i) % M;
        if (!found && i_m_req[cand]) begin
          sel   = IW'(cand);
          found = 1'b1;
        end
      end
    end
  end

  assign o_s_req = (|i_m_req) && !full;
  assign hs      = o_s_req && i_s_gnt;
  assign mux_idx = o_s_req ? sel : '0;

  // Forward the selected master's request fields to the slave.
  always_comb begin
    fwd.addr  = i_m_addr[32*int'(mux_idx) +: 32];
    fwd.wrcs  = i_m_wrcs[int'(mux_idx)];
    fwd.mask  = i_m_mask[4*int'(mux_idx) +: 4];
    fwd.wdata = i_m_wdata[32*int'(mux_idx) +: 32];
  end

  assign o_s_addr  = fwd.addr;
  assign o_s_wrcs  = fwd.wrcs;
  assign o_s_mask  = fwd.mask;
  assign o_s_wdata = fwd.wdata;

  // Grant goes only to the selected master, and only on a completed handshake.
  always_comb begin
    o_m_gnt = '0;
    if (hs) o_m_gnt[sel] = 1'b1;
  end

  // Responses go to the queue head; a response with nothing queued is dropped.
  always_comb begin
    o_m_rsp = '0;
    if (i_s_rsp && !empty) o_m_rsp[head] = 1'b1;
  end

  assign o_m_rdata = i_s_rdata;
  assign o_s_rdy   = !empty && i_m_rdy[head];
  assign pop       = i_s_rsp && o_s_rdy;

  // Hold a stalled request on its master until accepted; rotate priority on each handshake.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else begin
      if (hs) begin
        lock   <= 1'b0;
        rr_ptr <= (sel == IW'(M - 1)) ? '0 : sel + IW'(1);
      end else if (o_s_req && !i_s_gnt) begin
        lock     <= 1'b1;
        lock_idx <= sel;
      end
    end
  end

  // Sticky flag for a slave response that no master is waiting for.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_err <= 1'b0;
    end else if (i_s_rsp && empty) begin
      o_err <= 1'b1;
    end
  end

  rib_arb_fifo #(
    .WIDTH (IW),
    .DEPTH (OUTST)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .push  (hs),
    .pop   (pop),
    .wdata (sel),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

endmodule
